led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
Parametrised LED pattern engine that drives a NUM_LEDS-wide LED bank from the 50 MHz board clock. It replaces the fixed-table sequencer with algorithmic modes (sweep, bounce, fill, alternate), configurable endpoint hold, run/pause control, per-LED blanking and a two-digit BCD repeat counter. The BCD counter feeds the seven-segment decoders.

Parameters:
NUM_LEDS, 10, LED bank width (2..16)
CLK_DIV, 2500000, clk_50mhz cycles per step tick (>=2)
HOLD_TICKS, 10, extra ticks held at pattern endpoints (0 = no hold)
MAX_REPEATS, 99, repeat count wraps to 0 after this value (1..99)

Ports:
clk_50mhz  in  1  system clock, rising edge
key_zero_reset  in  1  asynchronous active-low reset
key_one_start  in  1  active-low pushbutton; press toggles run/pause
mode  in  2  00 sweep, 01 bounce, 10 fill, 11 alternate
led_mask  in  NUM_LEDS  1 = force that LED off
leds  out  NUM_LEDS  pattern AND NOT led_mask
repeat_tens  out  4  BCD tens of the completed-cycle count
repeat_ones  out  4  BCD ones of the completed-cycle count
running  out  1  1 while advancing
tick  out  1  one-cycle pulse on each step advance

Behaviour:
- Reset (key_zero_reset low, asynchronous): state IDLE, pattern 0, pos 0, dir up, divider 0, hold count 0, repeat 00, running 0, tick 0, synchroniser flops 1. leds = 0.
- key_one_start passes through a 2-flop synchroniser. A press is the 1->0 transition of the synchronised signal, giving one-cycle press_evt. Press-to-action latency is 3 clocks.
- States:
  - IDLE: pattern 0.
  - RUN: the divider counts.
  - HOLD: the divider counts; ticks decrement the hold count only.
  - PAUSED: the divider, pos and hold count freeze.
- Transitions on press_evt:
  - IDLE -> RUN: latch mode; pos 0; pattern for step 0 visible on the next edge.
  - RUN or HOLD -> PAUSED: remember the return state.
  - PAUSED -> the remembered state: the divider resumes from its frozen value.
- Divider: counts 0..CLK_DIV-1 while in RUN or HOLD. On the edge where it equals CLK_DIV-1: divider <= 0, tick <= 1, step logic executes. The pattern register updates on the same edge as tick rises.
- press_evt and a divider wrap in the same cycle: the pause wins, the tick is suppressed and the divider freezes at CLK_DIV-1. After resume, the tick fires on the first counted cycle.
- Step logic per mode (mode is latched only at IDLE->RUN and at each cycle completion; mid-cycle changes are ignored):
  - sweep: pattern = 1<<pos; pos increments and wraps N-1 -> 0; the wrap completes a cycle. No hold.
  - bounce: pattern = 1<<pos. Going up, reaching N-1 enters HOLD for HOLD_TICKS ticks, then dir = down. Going down, reaching 0 completes a cycle, enters HOLD, then dir = up.
  - fill: pattern = bits 0..pos set. Reaching pos N-1 enters HOLD, then the wrap to pos 0 completes a cycle.
  - alternate: pattern toggles between ...0101 and ...1010, starting with ...0101. Every second tick completes a cycle. No hold.
- HOLD with HOLD_TICKS=0 passes straight through with no extra tick.
- Repeat counter: BCD, increments on each cycle completion. The value after MAX_REPEATS is 00. Tens and ones are always valid BCD.
- leds = pattern & ~led_mask, combinational with zero latency. The mask never affects state.
- running = 1 in RUN and HOLD, 0 in IDLE and PAUSED.
- Reset asserted mid-operation returns every output to its reset value immediately. Operation restarts from IDLE only after a new press.

Test Plan:
(Bench parameters: NUM_LEDS=4, CLK_DIV=4, HOLD_TICKS=2, MAX_REPEATS=3.)
1. Reset, then idle for 100 clks without a press -> leds 0000, repeat 0/0, running 0, tick never high.
2. mode=00, press -> leds 0001, then every 4 clks 0010, 0100, 1000, 0001. repeat_ones goes to 1 on the 1000->0001 edge; tick is high for exactly 1 clk per step.
3. mode=01 -> step sequence 0001, 0010, 0100, 1000, 1000, 1000, 0100, 0010, 0001 (repeat_ones = 1), then 0001, 0001, 0010.
4. mode=10 with led_mask=0011 -> leds 0000, 0000, 0100, 1100, held for 2 ticks, then 0000 with repeat_ones = 1. Switching mode to 00 mid-cycle takes effect only after this wrap.
5. Press in RUN at divider=2 -> running 0, leds frozen for 50 clks. Press again -> the next tick arrives exactly 1 counted clk after resume. Pressing in the same cycle as a wrap suppresses that tick.
6. mode=11 for 8 ticks -> leds alternate 0101/1010; repeat_ones counts 1, 2, 3, 0. Pulling reset low mid-run -> leds 0000, BCD 0/0, running 0 in the same cycle.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - control and status bundle for the LED pattern sequencer
interface led_pattern_sequencer_if #(
  parameter int NUM_LEDS = 10
);
  logic                key_one_start;
  logic [1:0]          mode;
  logic [NUM_LEDS-1:0] led_mask;
  logic [NUM_LEDS-1:0] leds;
  logic [3:0]          repeat_tens;
  logic [3:0]          repeat_ones;
  logic                running;
  logic                tick;

  modport master (
    output key_one_start, mode, led_mask,
    input  leds, repeat_tens, repeat_ones, running, tick
  );

  modport slave (
    input  key_one_start, mode, led_mask,
    output leds, repeat_tens, repeat_ones, running, tick
  );
endinterface

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - algorithmic LED pattern engine with hold, pause and BCD repeat count
module led_pattern_sequencer #(
  parameter int NUM_LEDS    = 10,
  parameter int CLK_DIV     = 2500000,
  parameter int HOLD_TICKS  = 10,
  parameter int MAX_REPEATS = 99
) (
  input  logic                   clk_50mhz,
  input  logic                   key_zero_reset,
  led_pattern_sequencer_if.slave bus
);

  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 2);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
  localparam logic [3:0]        MAX_TENS  = 4'(MAX_REPEATS / 10);
  localparam logic [3:0]        MAX_ONES  = 4'(MAX_REPEATS % 10);

  localparam logic [1:0] M_SWEEP  = 2'b00;
  localparam logic [1:0] M_BOUNCE = 2'b01;
  localparam logic [1:0] M_FILL   = 2'b10;
  localparam logic [1:0] M_ALT    = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_PAUSED} state_t;

  state_t              state_q, state_d, ret_q;
  logic [2:0]          key_sync;
  logic [DIV_W-1:0]    div_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [POS_W-1:0]    pos_q;
  logic                dir_q;
  logic [1:0]          mode_q;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [3:0]          tens_q, ones_q;
  logic                tick_q;

  logic                press_evt, active, div_wrap, tick_fire;
  logic [POS_W-1:0]    step_pos;
  logic                step_dir, step_complete, step_endpoint;
  logic [1:0]          step_mode;
  logic [NUM_LEDS-1:0] step_pattern;
  logic [3:0]          tens_next, ones_next;

  function automatic logic [NUM_LEDS-1:0] pattern_of(input logic [1:0] m, input logic [POS_W-1:0] p);
    logic [NUM_LEDS-1:0] one_hot, fill_v, alt_v;
    for (int i = 0; i < NUM_LEDS; i++) begin
      one_hot[i] = (POS_W'(i) == p);
      fill_v[i]  = (POS_W'(i) <= p);
      alt_v[i]   = (i[0] == p[0]);
    end
    unique case (m)
      M_SWEEP, M_BOUNCE: pattern_of = one_hot;
      M_FILL:            pattern_of = fill_v;
      M_ALT:             pattern_of = alt_v;
    endcase
  endfunction

  // key_sync[1] is the synchronised button, key_sync[2] its previous value
  assign press_evt = key_sync[2] & ~key_sync[1];
  assign active    = (state_q == S_RUN) || (state_q == S_HOLD);
  assign div_wrap  = (div_q == DIV_LAST);
  assign tick_fire = active && div_wrap && !press_evt;

  always_comb begin
    step_pos      = pos_q;
    step_dir      = dir_q;
    step_complete = 1'b0;
    step_endpoint = 1'b0;
    unique case (mode_q)
      M_SWEEP: begin
        if (pos_q == POS_LAST) begin
          step_pos      = '0;
          step_complete = 1'b1;
        end else begin
          step_pos = pos_q + 1'b1;
        end
      end
      M_BOUNCE: begin
        if (dir_q == DIR_UP) begin
          step_pos = pos_q + 1'b1;
          if (step_pos == POS_LAST) begin
            step_endpoint = 1'b1;
            step_dir      = DIR_DOWN;
          end
        end else begin
          step_pos = pos_q - 1'b1;
          if (step_pos == '0) begin
            step_endpoint = 1'b1;
            step_complete = 1'b1;
          end
        end
      end
      M_FILL: begin
        if (pos_q == POS_LAST) begin
          step_pos      = '0;
          step_complete = 1'b1;
        end else begin
          step_pos      = pos_q + 1'b1;
          step_endpoint = (step_pos == POS_LAST);
        end
      end
      M_ALT: begin
        if (pos_q[0]) begin
          step_pos      = '0;
          step_complete = 1'b1;
        end else begin
          step_pos = POS_W'(1);
        end
      end
    endcase
    if (step_complete) step_dir = DIR_UP;
    // a new cycle picks up the live mode input; mid-cycle changes are ignored
    step_mode    = step_complete ? bus.mode : mode_q;
    step_pattern = pattern_of(step_mode, step_pos);
  end

  always_comb begin
    tens_next = tens_q;
    ones_next = ones_q + 1'b1;
    if (tens_q == MAX_TENS && ones_q == MAX_ONES) begin
      tens_next = '0;
      ones_next = '0;
    end else if (ones_q == 4'd9) begin
      tens_next = tens_q + 1'b1;
      ones_next = '0;
    end
  end

  always_ff @(posedge clk_50mhz or negedge key_zero_reset) begin
    if (!key_zero_reset) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (press_evt) state_d = S_RUN;
      S_RUN: begin
        if (press_evt)
          state_d = S_PAUSED;
        else if (tick_fire && step_endpoint && HOLD_TICKS != 0)
          state_d = S_HOLD;
      end
      S_HOLD: begin
        if (press_evt)
          state_d = S_PAUSED;
        else if (tick_fire && hold_q == HOLD_W'(1))
          state_d = S_RUN;
      end
      S_PAUSED: if (press_evt) state_d = ret_q;
    endcase
  end

  always_comb begin
    bus.running     = active;
    bus.tick        = tick_q;
    bus.leds        = pattern_q & ~bus.led_mask;
    bus.repeat_tens = tens_q;
    bus.repeat_ones = ones_q;
  end

  always_ff @(posedge clk_50mhz or negedge key_zero_reset) begin
    if (!key_zero_reset) begin
      key_sync  <= 3'b111;
      div_q     <= '0;
      hold_q    <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= M_SWEEP;
      pattern_q <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      tick_q    <= 1'b0;
      ret_q     <= S_RUN;
    end else begin
      key_sync <= {key_sync[1:0], bus.key_one_start};
      tick_q   <= tick_fire;

      // a pause landing on the wrap cycle parks the divider at its last count
      if (active) begin
        if (press_evt) begin
          ret_q <= state_q;
          if (!div_wrap) div_q <= div_q + 1'b1;
        end else begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
        end
      end

      if (state_q == S_IDLE && press_evt) begin
        mode_q    <= bus.mode;
        pos_q     <= '0;
        dir_q     <= DIR_UP;
        hold_q    <= '0;
        div_q     <= '0;
        pattern_q <= pattern_of(bus.mode, '0);
      end

      if (state_q == S_RUN && tick_fire) begin
        pos_q     <= step_pos;
        dir_q     <= step_dir;
        pattern_q <= step_pattern;
        mode_q    <= step_mode;
        if (step_endpoint) hold_q <= HOLD_INIT;
        if (step_complete) begin
          tens_q <= tens_next;
          ones_q <= ones_next;
        end
      end

      if (state_q == S_HOLD && tick_fire) hold_q <= hold_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer
module tb_led_pattern_sequencer;
  localparam int N  = 4;
  localparam int CD = 4;
  localparam int HT = 2;
  localparam int MR = 3;

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] ones;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  led_pattern_sequencer_if #(.NUM_LEDS(N)) bus ();

  led_pattern_sequencer #(
    .NUM_LEDS(N), .CLK_DIV(CD), .HOLD_TICKS(HT), .MAX_REPEATS(MR)
  ) dut (
    .clk_50mhz      (clk),
    .key_zero_reset (rst_n),
    .bus            (bus)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.key_one_start = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // returns at the negedge just after the edge that acts on the press
  task automatic press();
    bus.key_one_start = 1'b0;
    repeat (3) @(negedge clk);
    bus.key_one_start = 1'b1;
  endtask

  task automatic wait_tick(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) begin
        gap = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.leds, bus.repeat_tens, bus.repeat_ones, bus.running, bus.tick} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: leds=%b tens=%0d ones=%0d running=%b tick=%b, expected all zero",
               bus.leds, bus.repeat_tens, bus.repeat_ones, bus.running, bus.tick);
    end
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tick !== 1'b0 || bus.running !== 1'b0 || bus.leds !== 4'b0000) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_press: activity seen=%b, expected 0", bad);
    end
    n_tests++;
    if ({bus.repeat_tens, bus.repeat_ones} !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_repeat: got %h, expected 00", {bus.repeat_tens, bus.repeat_ones});
    end
  endtask

  task automatic test_sweep();
    int gap;
    bit ok;
    bus.mode = 2'b00;
    bus.led_mask = 4'b0000;
    do_reset();
    press();
    n_tests++;
    if ({bus.leds, bus.running, bus.tick} !== {4'b0001, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sweep_entry: leds=%b running=%b tick=%b, expected 0001 1 0", bus.leds, bus.running, bus.tick);
    end
    sb.push_back({4'b0010, 4'd0});
    sb.push_back({4'b0100, 4'd0});
    sb.push_back({4'b1000, 4'd0});
    sb.push_back({4'b0001, 4'd1});
    for (int i = 0; sb.size() > 0; i++) begin
      exp_t e;
      e = sb.pop_front();
      wait_tick(gap, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL sweep_timeout step%0d: no tick, expected leds=%b", i, e.leds);
        sb.delete();
      end else begin
        if ({bus.leds, bus.repeat_ones, bus.repeat_tens} !== {e.leds, e.ones, 4'd0}) begin
          n_fail++;
          $display("FAIL sweep_step%0d: leds=%b ones=%0d tens=%0d, expected leds=%b ones=%0d tens=0",
                   i, bus.leds, bus.repeat_ones, bus.repeat_tens, e.leds, e.ones);
        end
        n_tests++;
        if (gap !== CD) begin
          n_fail++;
          $display("FAIL sweep_gap%0d: tick spacing %0d clks, expected %0d", i, gap, CD);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int gap;
    bit ok;
    logic [3:0] seq [11] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0100,
                            4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    bus.mode = 2'b01;
    bus.led_mask = 4'b0000;
    do_reset();
    press();
    n_tests++;
    if (bus.leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL bounce_entry: leds=%b, expected 0001", bus.leds);
    end
    for (int i = 0; i < 11; i++) sb.push_back({seq[i], (i >= 7) ? 4'd1 : 4'd0});
    for (int i = 0; sb.size() > 0; i++) begin
      exp_t e;
      e = sb.pop_front();
      wait_tick(gap, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL bounce_timeout step%0d: no tick, expected leds=%b", i, e.leds);
        sb.delete();
      end else if ({bus.leds, bus.repeat_ones, bus.running} !== {e.leds, e.ones, 1'b1}) begin
        n_fail++;
        $display("FAIL bounce_step%0d: leds=%b ones=%0d running=%b, expected leds=%b ones=%0d running=1",
                 i, bus.leds, bus.repeat_ones, bus.running, e.leds, e.ones);
      end
    end
  endtask

  task automatic test_fill_mask();
    int gap;
    bit ok;
    logic [3:0] seq [10] = '{4'b0000, 4'b0100, 4'b1100, 4'b1100, 4'b1100, 4'b0000,
                            4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.mode = 2'b10;
    bus.led_mask = 4'b0011;
    do_reset();
    press();
    n_tests++;
    if (bus.leds !== 4'b0000) begin
      n_fail++;
      $display("FAIL fill_entry: leds=%b, expected 0000", bus.leds);
    end
    for (int i = 0; i < 10; i++) sb.push_back({seq[i], (i == 9) ? 4'd2 : (i >= 5) ? 4'd1 : 4'd0});
    for (int i = 0; sb.size() > 0; i++) begin
      exp_t e;
      e = sb.pop_front();
      wait_tick(gap, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL fill_timeout step%0d: no tick, expected leds=%b", i, e.leds);
        sb.delete();
      end else if ({bus.leds, bus.repeat_ones} !== {e.leds, e.ones}) begin
        n_fail++;
        $display("FAIL fill_step%0d: leds=%b ones=%0d, expected leds=%b ones=%0d",
                 i, bus.leds, bus.repeat_ones, e.leds, e.ones);
      end
      if (i == 1) bus.mode = 2'b00;
      if (i == 5) begin
        bus.led_mask = 4'b0000;
        #1;
        n_tests++;
        if (bus.leds !== 4'b0001) begin
          n_fail++;
          $display("FAIL mask_release: leds=%b, expected 0001", bus.leds);
        end
      end
    end
  endtask

  task automatic test_pause();
    int gap;
    bit ok;
    bit bad;
    bus.mode = 2'b00;
    bus.led_mask = 4'b0000;
    do_reset();
    press();
    wait_tick(gap, ok);
    n_tests++;
    if (!ok || bus.leds !== 4'b0010) begin
      n_fail++;
      $display("FAIL pause_first_tick: ok=%b leds=%b, expected 1 0010", ok, bus.leds);
    end
    press();
    n_tests++;
    if ({bus.running, bus.leds} !== {1'b0, 4'b0010}) begin
      n_fail++;
      $display("FAIL pause_enter: running=%b leds=%b, expected 0 0010", bus.running, bus.leds);
    end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.leds !== 4'b0010 || bus.running !== 1'b0 || bus.tick !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_frozen: change seen=%b, expected 0", bad);
    end
    press();
    wait_tick(gap, ok);
    n_tests++;
    if ({ok, gap[7:0], bus.leds} !== {1'b1, 8'd1, 4'b0100}) begin
      n_fail++;
      $display("FAIL resume_tick: ok=%b gap=%0d leds=%b, expected 1 1 0100", ok, gap, bus.leds);
    end
    @(negedge clk);
    press();
    n_tests++;
    if ({bus.tick, bus.running, bus.leds} !== {1'b0, 1'b0, 4'b0100}) begin
      n_fail++;
      $display("FAIL wrap_pause: tick=%b running=%b leds=%b, expected 0 0 0100", bus.tick, bus.running, bus.leds);
    end
    repeat (5) @(negedge clk);
    press();
    wait_tick(gap, ok);
    n_tests++;
    if ({ok, gap[7:0], bus.leds} !== {1'b1, 8'd1, 4'b1000}) begin
      n_fail++;
      $display("FAIL wrap_resume: ok=%b gap=%0d leds=%b, expected 1 1 1000", ok, gap, bus.leds);
    end
  endtask

  task automatic test_alternate_reset();
    int gap;
    bit ok;
    bit bad;
    logic [3:0] ones_seq [11] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 4'd1, 4'd1};
    bus.mode = 2'b11;
    bus.led_mask = 4'b0000;
    do_reset();
    press();
    n_tests++;
    if (bus.leds !== 4'b0101) begin
      n_fail++;
      $display("FAIL alt_entry: leds=%b, expected 0101", bus.leds);
    end
    for (int i = 0; i < 11; i++) sb.push_back({(i % 2 == 0) ? 4'b1010 : 4'b0101, ones_seq[i]});
    for (int i = 0; sb.size() > 0; i++) begin
      exp_t e;
      e = sb.pop_front();
      wait_tick(gap, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL alt_timeout step%0d: no tick, expected leds=%b", i, e.leds);
        sb.delete();
      end else if ({bus.leds, bus.repeat_ones, bus.repeat_tens} !== {e.leds, e.ones, 4'd0}) begin
        n_fail++;
        $display("FAIL alt_step%0d: leds=%b ones=%0d tens=%0d, expected leds=%b ones=%0d tens=0",
                 i, bus.leds, bus.repeat_ones, bus.repeat_tens, e.leds, e.ones);
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.leds, bus.repeat_tens, bus.repeat_ones, bus.running, bus.tick} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: leds=%b tens=%0d ones=%0d running=%b tick=%b, expected all zero",
               bus.leds, bus.repeat_tens, bus.repeat_ones, bus.running, bus.tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.running !== 1'b0 || bus.leds !== 4'b0000 || bus.tick !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_needs_press: activity seen=%b, expected 0", bad);
    end
  endtask

  initial begin
    bus.key_one_start = 1'b1;
    bus.mode = 2'b00;
    bus.led_mask = 4'b0000;
    test_reset();
    test_sweep();
    test_bounce();
    test_fill_mask();
    test_pause();
    test_alternate_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
